// File: rtl/counter_mode_sequencer.sv
// counter_mode_sequencer: steps the 4-bit mode counter through a small table
// of {duration, mode} entries, issuing clear and count ticks and reporting progress.
//   clk_2, reset         : clock (rising edge), async active-low reset
//   cfg_we/addr/data     : table write port, accepted only in IDLE and DONE
//   start, stop          : run request (level) and abort
//   count_in             : counter value fed back, used for the saturation exit
//   cnt_clear, cnt_en    : counter clear and one-cycle count tick
//   cnt_dec/inc3/freeze/sat : mode of the current step
//   step_idx, busy, done : progress reporting
module counter_mode_sequencer #(
  parameter int unsigned NSTEPS   = 4,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic                       clk_2,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [$clog2(NSTEPS)-1:0]  cfg_addr,
  input  logic [7:0]                 cfg_data,
  input  logic                       start,
  input  logic                       stop,
  input  logic [3:0]                 count_in,
  output logic                       cnt_clear,
  output logic                       cnt_en,
  output logic                       cnt_dec,
  output logic                       cnt_inc3,
  output logic                       cnt_freeze,
  output logic                       cnt_sat,
  output logic [$clog2(NSTEPS)-1:0]  step_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned AW  = $clog2(NSTEPS);
  localparam int unsigned TDW = $clog2(TICK_DIV);
  localparam logic [AW-1:0]  STEP_LAST = AW'(NSTEPS - 1);
  localparam logic [TDW-1:0] TDIV_LAST = TDW'(TICK_DIV - 1);
  localparam logic [TDW-1:0] TDIV_ARM  = TDW'(TICK_DIV - 2);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic sat;
    logic freeze;
    logic inc3;
    logic dec;
  } mode_t;

  typedef struct packed {
    logic [3:0] dur;
    mode_t      mode;
  } entry_t;

  state_e         r_state;
  entry_t         r_table [NSTEPS];
  logic [TDW-1:0] r_tdiv;
  logic [3:0]     r_rem;
  logic [AW-1:0]  r_step;
  logic           r_cnt_clear;
  logic           r_cnt_en;
  mode_t          r_mode;
  logic           r_busy;
  logic           r_done;

  logic [AW-1:0]  w_step_inc;
  entry_t         w_nxt_entry;
  logic [3:0]     w_rem_after;
  logic           w_adv;
  logic           w_arm_tick;
  logic           w_sat_hit;

  assign w_step_inc  = r_step + AW'(1);
  assign w_nxt_entry = r_table[w_step_inc];
  // r_cnt_en marks the current cycle as a tick, which consumes one unit of duration
  assign w_rem_after = r_cnt_en ? (r_rem - 4'd1) : r_rem;
  // Zero remaining covers both skipped (duration 0) steps and a saturation exit
  assign w_adv       = (r_rem == 4'd0) || (r_cnt_en && (r_rem == 4'd1));
  // The next cycle is a tick slot with duration left
  assign w_arm_tick  = (r_tdiv == TDIV_ARM) && (w_rem_after != 4'd0);
  // count_in only moves on a tick, so its value at the edge entering a tick
  // slot is the value the counter holds during that slot
  assign w_sat_hit   = r_mode.sat && (r_mode.dec ? (count_in == 4'd0) : (count_in == 4'hF));

  // Step table; writes only while not sequencing
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NSTEPS; i++) begin
        r_table[AW'(i)] <= '0;
      end
    end else if (cfg_we && ((r_state == S_IDLE) || (r_state == S_DONE))) begin
      r_table[cfg_addr] <= entry_t'(cfg_data);
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_tdiv      <= '0;
      r_rem       <= '0;
      r_step      <= '0;
      r_cnt_clear <= 1'b0;
      r_cnt_en    <= 1'b0;
      r_mode      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cnt_clear <= 1'b0;
      r_cnt_en    <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_state     <= S_CLEAR;
            r_cnt_clear <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_RUN;
            r_step  <= '0;
            r_tdiv  <= '0;
            r_rem   <= r_table[0].dur;
            r_mode  <= r_table[0].mode;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_mode  <= '0;
            r_step  <= '0;
            r_tdiv  <= '0;
            r_rem   <= '0;
          end else if (w_adv) begin
            r_tdiv <= '0;
            if (r_step == STEP_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_mode  <= '0;
              r_step  <= '0;
              r_rem   <= '0;
            end else begin
              r_step <= w_step_inc;
              r_rem  <= w_nxt_entry.dur;
              r_mode <= w_nxt_entry.mode;
            end
          end else begin
            r_tdiv <= (r_tdiv == TDIV_LAST) ? '0 : (r_tdiv + TDW'(1));
            if (w_arm_tick && w_sat_hit) begin
              // Saturated: suppress this tick and end the step after it
              r_rem <= '0;
            end else begin
              r_cnt_en <= w_arm_tick;
              r_rem    <= w_rem_after;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cnt_clear  = r_cnt_clear;
  assign cnt_en     = r_cnt_en;
  assign cnt_dec    = r_mode.dec;
  assign cnt_inc3   = r_mode.inc3;
  assign cnt_freeze = r_mode.freeze;
  assign cnt_sat    = r_mode.sat;
  assign step_idx   = r_step;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
